// File: rtl/alu_decode_stage_pkg.sv
// alu_decode_stage_pkg
// Shared definitions for the decode stage: ALU control bit positions, the
// control-bus width, MIPS opcode/funct encodings (including the custom
// nand/sht/shtu/lli R-type functs) and the operand/destination select enums.
// No ports; imported by alu_op_decode and alu_decode_stage.
package alu_decode_stage_pkg;

    localparam int ALU_CTRL_W = 16;

    // One-hot bit positions on the ALU control bus
    localparam int ALU_LLI  = 15;
    localparam int ALU_NAND = 14;
    localparam int ALU_SHTU = 13;
    localparam int ALU_SHT  = 12;
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_NAND = 6'h28;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;
    localparam logic [5:0] FUNCT_SHT  = 6'h2C;
    localparam logic [5:0] FUNCT_SHTU = 6'h2D;
    localparam logic [5:0] FUNCT_LLI  = 6'h2E;

    typedef enum logic {SRC1_RS, SRC1_SHAMT} src1_sel_e;
    typedef enum logic [1:0] {SRC2_RT, SRC2_SEXT, SRC2_ZEXT} src2_sel_e;
    typedef enum logic {DEST_RD, DEST_RT} dest_sel_e;

    function automatic logic [ALU_CTRL_W-1:0] alu_bit(input int idx);
        logic [ALU_CTRL_W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/alu_decode_stage_op_decode.sv
// alu_op_decode
// Combinational opcode/funct decoder. Produces the one-hot ALU control and
// the select codes the stage uses for its operand and destination muxes.
// Ports:
//   opcode      in   inst[31:26]
//   funct       in   inst[5:0]
//   alu_control out  one-hot ALU op, all-zero for an illegal encoding
//   src1_sel    out  rs data or zero-extended shamt
//   src2_sel    out  rt data, sign- or zero-extended imm16
//   dest_sel    out  rd (R-type) or rt (I-type)
//   illegal     out  unrecognised opcode/funct
module alu_op_decode
    import alu_decode_stage_pkg::*;
(
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output src1_sel_e             src1_sel,
    output src2_sel_e             src2_sel,
    output dest_sel_e             dest_sel,
    output logic                  illegal
);

    always_comb begin
        alu_control = '0;
        src1_sel    = SRC1_RS;
        src2_sel    = SRC2_RT;
        dest_sel    = DEST_RD;
        illegal     = 1'b0;
        if (opcode == OPC_RTYPE) begin
            unique case (funct)
                FUNCT_ADD, FUNCT_ADDU: alu_control = alu_bit(ALU_ADD);
                FUNCT_SUB, FUNCT_SUBU: alu_control = alu_bit(ALU_SUB);
                FUNCT_AND:  alu_control = alu_bit(ALU_AND);
                FUNCT_OR:   alu_control = alu_bit(ALU_OR);
                FUNCT_XOR:  alu_control = alu_bit(ALU_XOR);
                FUNCT_NOR:  alu_control = alu_bit(ALU_NOR);
                FUNCT_NAND: alu_control = alu_bit(ALU_NAND);
                FUNCT_SLT:  alu_control = alu_bit(ALU_SLT);
                FUNCT_SLTU: alu_control = alu_bit(ALU_SLTU);
                FUNCT_SHT:  alu_control = alu_bit(ALU_SHT);
                FUNCT_SHTU: alu_control = alu_bit(ALU_SHTU);
                FUNCT_LLI:  alu_control = alu_bit(ALU_LLI);
                // Immediate shifts take the amount from the shamt field
                FUNCT_SLL: begin alu_control = alu_bit(ALU_SLL); src1_sel = SRC1_SHAMT; end
                FUNCT_SRL: begin alu_control = alu_bit(ALU_SRL); src1_sel = SRC1_SHAMT; end
                FUNCT_SRA: begin alu_control = alu_bit(ALU_SRA); src1_sel = SRC1_SHAMT; end
                FUNCT_SLLV: alu_control = alu_bit(ALU_SLL);
                FUNCT_SRLV: alu_control = alu_bit(ALU_SRL);
                FUNCT_SRAV: alu_control = alu_bit(ALU_SRA);
                default:    illegal = 1'b1;
            endcase
        end else begin
            dest_sel = DEST_RT;
            unique case (opcode)
                OPC_ADDIU: begin alu_control = alu_bit(ALU_ADD);  src2_sel = SRC2_SEXT; end
                OPC_SLTI:  begin alu_control = alu_bit(ALU_SLT);  src2_sel = SRC2_SEXT; end
                OPC_SLTIU: begin alu_control = alu_bit(ALU_SLTU); src2_sel = SRC2_SEXT; end
                OPC_ANDI:  begin alu_control = alu_bit(ALU_AND);  src2_sel = SRC2_ZEXT; end
                OPC_ORI:   begin alu_control = alu_bit(ALU_OR);   src2_sel = SRC2_ZEXT; end
                OPC_XORI:  begin alu_control = alu_bit(ALU_XOR);  src2_sel = SRC2_ZEXT; end
                // The ALU does the 16-bit move into the upper half
                OPC_LUI:   begin alu_control = alu_bit(ALU_LUI);  src2_sel = SRC2_ZEXT; end
                default:   illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// Decode stage between IF and EXE. Decodes one instruction per handshake,
// builds the two ALU operands from the register-file read data or the
// immediate/shamt fields, and registers them with the one-hot ALU control
// and write-back info. Single-entry output register, latency 1.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop the held instruction and any same-cycle load
//   in_valid/in_ready   upstream handshake, in_inst instruction word
//   rs_addr/rt_addr     register-file read addresses (combinational)
//   rs_rdata/rt_rdata   register-file read data, same cycle
//   out_valid/out_ready downstream handshake
//   alu_control         one-hot ALU op
//   alu_src1/alu_src2   ALU operands
//   wb_dest/wb_wen      write-back register and enable
//   out_illegal         unrecognised encoding
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = ALU_CTRL_W,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_rdata,
    input  logic [DATA_W-1:0] rt_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [REG_AW-1:0] wb_dest,
    output logic              wb_wen,
    output logic              out_illegal
);

    logic [CTRL_W-1:0] dec_control;
    src1_sel_e         src1_sel;
    src2_sel_e         src2_sel;
    dest_sel_e         dest_sel;
    logic              dec_illegal;
    logic [DATA_W-1:0] src1_nxt;
    logic [DATA_W-1:0] src2_nxt;
    logic [REG_AW-1:0] dest_nxt;
    logic              wen_nxt;
    logic              load;

    assign rs_addr  = in_inst[25:21];
    assign rt_addr  = in_inst[20:16];
    assign in_ready = ~out_valid | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    alu_op_decode u_op_decode (
        .opcode      (in_inst[31:26]),
        .funct       (in_inst[5:0]),
        .alu_control (dec_control),
        .src1_sel    (src1_sel),
        .src2_sel    (src2_sel),
        .dest_sel    (dest_sel),
        .illegal     (dec_illegal)
    );

    always_comb begin
        src1_nxt = rs_rdata;
        if (src1_sel == SRC1_SHAMT)
            src1_nxt = {{(DATA_W-5){1'b0}}, in_inst[10:6]};
        case (src2_sel)
            SRC2_SEXT: src2_nxt = {{(DATA_W-16){in_inst[15]}}, in_inst[15:0]};
            SRC2_ZEXT: src2_nxt = {{(DATA_W-16){1'b0}}, in_inst[15:0]};
            default:   src2_nxt = rt_rdata;
        endcase
        dest_nxt = (dest_sel == DEST_RT) ? in_inst[20:16] : in_inst[15:11];
        // $0 writes are suppressed here so EXE/WB never need to check
        wen_nxt  = ~dec_illegal & (dest_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            alu_control <= '0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            wb_dest     <= '0;
            wb_wen      <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (load) begin
                alu_control <= dec_control;
                alu_src1    <= src1_nxt;
                alu_src2    <= src2_nxt;
                wb_dest     <= dest_nxt;
                wb_wen      <= wen_nxt;
                out_illegal <= dec_illegal;
            end
            if (flush)
                out_valid <= 1'b0;
            else if (load)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
